// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         SRAM_WAIT_DEF = 4;
  localparam int         WAIT_CNT_W    = 4;

  // Register 0 is hardwired to zero, so it can never carry a true dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW comparator between the ID instruction and the EXE/MEM writers.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [4:0] id_src1_i,
  input  logic [4:0] id_src2_i,
  input  logic       id_two_src_i,
  input  logic [4:0] exe_dst_i,
  input  logic       exe_wb_en_i,
  input  logic       exe_mem_r_en_i,
  input  logic [4:0] mem_dst_i,
  input  logic       mem_wb_en_i,
  output logic       hazard_o
);

  logic hits_exe;
  logic hits_mem;
  logic load_use;
  logic raw_any;

  assign hits_exe = reg_match(exe_dst_i, id_src1_i) |
                    (id_two_src_i & reg_match(exe_dst_i, id_src2_i));
  assign hits_mem = reg_match(mem_dst_i, id_src1_i) |
                    (id_two_src_i & reg_match(mem_dst_i, id_src2_i));

  assign load_use = exe_mem_r_en_i & exe_wb_en_i & hits_exe;
  assign raw_any  = (exe_wb_en_i & hits_exe) | (mem_wb_en_i & hits_mem);

  // With forwarding, only a load in EXE cannot be bypassed in time.
  assign hazard_o = FWD_EN ? load_use : raw_any;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: SRAM wait FSM, branch flush,
// data-hazard bubbles and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int SRAM_WAIT = SRAM_WAIT_DEF,
  parameter bit FWD_EN    = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic [4:0]       exe_dst,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [4:0]       mem_dst,
  input  logic             mem_wb_en,
  input  logic             mem_access,
  input  logic             br_taken,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idex_freeze,
  output logic             idex_flush,
  output logic             exmem_freeze,
  output logic             sram_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The IDLE cycle that sees mem_access freezes too, so WAIT only covers the
  // remaining SRAM_WAIT-2 cycles; DONE then releases the MEM instruction.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(SRAM_WAIT - 2);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]      stall_cnt_q, flush_cnt_q;
  logic                  hazard;
  logic                  sram_freeze;

  hazard_detect #(.FWD_EN(FWD_EN)) u_hazard_detect (
    .id_src1_i      (id_src1),
    .id_src2_i      (id_src2),
    .id_two_src_i   (id_two_src),
    .exe_dst_i      (exe_dst),
    .exe_wb_en_i    (exe_wb_en),
    .exe_mem_r_en_i (exe_mem_r_en),
    .mem_dst_i      (mem_dst),
    .mem_wb_en_i    (mem_wb_en),
    .hazard_o       (hazard)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mem_access) begin
          if (WAIT_LOAD == '0) begin
            state_d = DONE;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 1'b1;
        if (wait_cnt_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sram_freeze = ((state_q == IDLE) && mem_access) || (state_q == WAIT);

  always_comb begin
    pc_freeze    = 1'b0;
    ifid_freeze  = 1'b0;
    ifid_flush   = 1'b0;
    idex_freeze  = 1'b0;
    idex_flush   = 1'b0;
    exmem_freeze = 1'b0;
    sram_busy    = 1'b0;
    if (rst) begin
      // Everything stays released while reset is asserted.
    end else if (sram_freeze) begin
      sram_busy    = 1'b1;
      pc_freeze    = 1'b1;
      ifid_freeze  = 1'b1;
      idex_freeze  = 1'b1;
      exmem_freeze = 1'b1;
    end else if (br_taken) begin
      // ID holds a wrong-path instruction, so a pending hazard is moot.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hazard) begin
      pc_freeze   = 1'b1;
      ifid_freeze = 1'b1;
      idex_flush  = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (pc_freeze && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: one forwarding instance (SRAM_WAIT=4) and one non-forwarding
// instance (SRAM_WAIT=2, 3-bit counters) driven by the same stimulus.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_src1, id_src2, exe_dst, mem_dst;
  logic       id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_access, br_taken;

  logic        a_pc_f, a_ifid_f, a_ifid_fl, a_idex_f, a_idex_fl, a_exmem_f, a_busy;
  logic [15:0] a_stall, a_flush;
  logic        b_pc_f, b_ifid_f, b_ifid_fl, b_idex_f, b_idex_fl, b_exmem_f, b_busy;
  logic [2:0]  b_stall, b_flush;

  int checks   = 0;
  int failures = 0;

  // Output vectors: {pc_f, ifid_f, ifid_fl, idex_f, idex_fl, exmem_f, busy}
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] LUSE  = 7'b1100100;
  localparam logic [6:0] BRANCH = 7'b0010100;
  localparam logic [6:0] SRAM  = 7'b1101011;

  logic [6:0] outs_a, outs_b;
  assign outs_a = {a_pc_f, a_ifid_f, a_ifid_fl, a_idex_f, a_idex_fl, a_exmem_f, a_busy};
  assign outs_b = {b_pc_f, b_ifid_f, b_ifid_fl, b_idex_f, b_idex_fl, b_exmem_f, b_busy};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.SRAM_WAIT(4), .FWD_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dst(exe_dst), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dst(mem_dst), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
    .br_taken(br_taken),
    .pc_freeze(a_pc_f), .ifid_freeze(a_ifid_f), .ifid_flush(a_ifid_fl),
    .idex_freeze(a_idex_f), .idex_flush(a_idex_fl), .exmem_freeze(a_exmem_f),
    .sram_busy(a_busy), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipeline_hazard_ctrl #(.SRAM_WAIT(2), .FWD_EN(1'b0), .CNT_W(3)) dut_nofwd (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dst(exe_dst), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dst(mem_dst), .mem_wb_en(mem_wb_en), .mem_access(mem_access),
    .br_taken(br_taken),
    .pc_freeze(b_pc_f), .ifid_freeze(b_ifid_f), .ifid_flush(b_ifid_fl),
    .idex_freeze(b_idex_f), .idex_flush(b_idex_fl), .exmem_freeze(b_exmem_f),
    .sram_busy(b_busy), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
    exe_dst = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dst = '0; mem_wb_en = 1'b0; mem_access = 1'b0; br_taken = 1'b0;
  endtask

  initial begin
    // Reset: outputs forced low even with requests pending.
    clear_inputs();
    rst = 1'b1; mem_access = 1'b1; br_taken = 1'b1;
    #1 check("rst_outs", 32'(outs_a), 32'(NONE));
    cyc(); cyc();
    rst = 1'b0; clear_inputs();
    #1;
    check("post_rst_outs", 32'(outs_a), 32'(NONE));
    check("post_rst_stall", 32'(a_stall), 0);
    check("post_rst_flush", 32'(a_flush), 0);
    cyc();

    // Load-use on src1.
    exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dst = 5'd5; id_src1 = 5'd5;
    #1 check("luse_src1", 32'(outs_a), 32'(LUSE));
    cyc();
    check("luse_stall_cnt", 32'(a_stall), 1);

    // Destination r0 never hazards.
    exe_dst = 5'd0; id_src1 = 5'd0;
    #1 check("luse_r0", 32'(outs_a), 32'(NONE));
    cyc();

    // src2 only counts when the instruction reads it.
    exe_dst = 5'd9; id_src1 = 5'd3; id_src2 = 5'd9; id_two_src = 1'b0;
    #1 check("luse_src2_unused", 32'(outs_a), 32'(NONE));
    cyc();
    id_two_src = 1'b1;
    #1 check("luse_src2", 32'(outs_a), 32'(LUSE));
    cyc();
    check("luse_stall_cnt2", 32'(a_stall), 2);

    exe_wb_en = 1'b0;
    #1 check("load_no_wb", 32'(outs_a), 32'(NONE));
    cyc();

    // Branch overrides a simultaneous load-use.
    exe_wb_en = 1'b1; br_taken = 1'b1;
    #1 check("branch_over_luse", 32'(outs_a), 32'(BRANCH));
    cyc();
    check("branch_flush_cnt", 32'(a_flush), 1);
    check("branch_stall_cnt", 32'(a_stall), 2);
    clear_inputs();
    cyc();

    // Isolated SRAM access with a branch arriving mid-freeze.
    mem_access = 1'b1;
    #1 check("sram_f1", 32'(outs_a), 32'(SRAM));
    cyc();
    mem_access = 1'b0; br_taken = 1'b1;
    #1 check("sram_f2_branch_held", 32'(outs_a), 32'(SRAM));
    cyc();
    #1 check("sram_f3", 32'(outs_a), 32'(SRAM));
    cyc();
    #1 check("sram_done_branch", 32'(outs_a), 32'(BRANCH));
    cyc();
    br_taken = 1'b0;
    #1 check("sram_idle", 32'(outs_a), 32'(NONE));
    check("sram_stall_cnt", 32'(a_stall), 5);
    check("sram_flush_cnt", 32'(a_flush), 2);
    cyc();

    // Back-to-back: mem_access held through DONE.
    mem_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("b2b_a%0d", i), 32'(outs_a), 32'(SRAM));
      cyc();
    end
    #1 check("b2b_done", 32'(outs_a), 32'(NONE));
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("b2b_b%0d", i), 32'(outs_a), 32'(SRAM));
      cyc();
    end
    mem_access = 1'b0;
    #1 check("b2b_done2", 32'(outs_a), 32'(NONE));
    check("b2b_stall_cnt", 32'(a_stall), 11);
    cyc();

    // Reset in the second WAIT cycle.
    mem_access = 1'b1;
    cyc();
    mem_access = 1'b0;
    cyc();
    rst = 1'b1;
    #1 check("rst_mid_wait_outs", 32'(outs_a), 32'(NONE));
    cyc();
    rst = 1'b0;
    #1;
    check("after_rst_outs", 32'(outs_a), 32'(NONE));
    check("after_rst_stall", 32'(a_stall), 0);
    check("after_rst_flush", 32'(a_flush), 0);
    cyc();
    mem_access = 1'b1;
    #1 check("after_rst_restart", 32'(outs_a), 32'(SRAM));
    cyc();
    mem_access = 1'b0;
    cyc(); cyc(); cyc();

    // Forwarding vs no forwarding.
    mem_wb_en = 1'b1; mem_dst = 5'd7; id_two_src = 1'b1; id_src2 = 5'd7;
    #1;
    check("nofwd_mem_raw", 32'(outs_b), 32'(LUSE));
    check("fwd_mem_raw", 32'(outs_a), 32'(NONE));
    cyc();
    clear_inputs();
    exe_wb_en = 1'b1; exe_dst = 5'd4; id_src1 = 5'd4;
    #1;
    check("nofwd_exe_raw", 32'(outs_b), 32'(LUSE));
    check("fwd_exe_alu", 32'(outs_a), 32'(NONE));
    cyc();
    clear_inputs();
    mem_wb_en = 1'b1; mem_dst = 5'd0; id_src1 = 5'd0;
    #1 check("nofwd_r0", 32'(outs_b), 32'(NONE));
    cyc();

    // Counter saturation on the 3-bit instance.
    clear_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mem_wb_en = 1'b1; mem_dst = 5'd7; id_two_src = 1'b1; id_src2 = 5'd7;
    for (int i = 0; i < 7; i++) cyc();
    check("sat_reach", 32'(b_stall), 7);
    cyc(); cyc();
    check("sat_hold", 32'(b_stall), 7);
    check("sat_fwd_none", 32'(a_stall), 0);

    // Minimum SRAM_WAIT=2: one freeze cycle, then release.
    clear_inputs();
    mem_access = 1'b1;
    #1 check("w2_freeze", 32'(outs_b), 32'(SRAM));
    cyc();
    mem_access = 1'b0;
    #1;
    check("w2_done", 32'(outs_b), 32'(NONE));
    check("w4_still_frozen", 32'(outs_a), 32'(SRAM));
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
